// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered UART transmitter: line defaults,
// bit-divisor helper and FSM state encoding.
package uart_tx_fifo_pkg;

    localparam int DEF_CLK_FREQ  = 50_000_000;
    localparam int DEF_BAUD_RATE = 115200;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Truncating divisor so the receiver and transmitter agree on bit length.
    function automatic int baud_div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte push handshake into the transmitter FIFO.
interface uart_tx_fifo_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock circular FIFO with registered count and full flag.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             push_ok, pop_ok;

    // A push while full is dropped even if a pop frees a slot this cycle.
    assign push_ok = push && !full_q;
    assign pop_ok  = pop && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem[rd_ptr_q];
    assign full    = full_q;
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1/8N2 UART transmitter: FIFO front end, LSB-first serialiser
// with a registered, glitch-free line output.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int CLK_FREQ   = DEF_CLK_FREQ,
    parameter int BAUD_RATE  = DEF_BAUD_RATE,
    parameter int STOP_BITS  = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    uart_tx_fifo_if.slave                 s_if,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int DIV = baud_div(CLK_FREQ, BAUD_RATE);
    localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    tx_state_e     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          overflow_q, overflow_d;

    logic          pop;
    logic [7:0]    fifo_rd_data;
    logic          fifo_full, fifo_empty;
    logic          baud_done;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (s_if.tx_valid),
        .wr_data (s_if.tx_data),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign baud_done = (baud_q == BAUD_LAST);

    always_comb begin
        state_d    = state_q;
        baud_d     = '0;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        pop        = 1'b0;
        tx_d       = 1'b1;
        busy_d     = (state_q != ST_IDLE) || !fifo_empty;
        overflow_d = s_if.tx_valid && fifo_full;

        if (state_q != ST_IDLE) baud_d = baud_done ? '0 : baud_q + BW'(1);

        // tx_d follows the current state, so the line lags the FSM by one cycle.
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_rd_data;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (baud_done) begin
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_d = shreg_q[0];
                if (baud_done) begin
                    shreg_d = shreg_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (baud_done) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == STOP_LAST) begin
                        bit_d   = 3'd0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign s_if.tx_ready = !fifo_full;
    assign tx            = tx_q;
    assign busy          = busy_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: default-rate latency/frame check plus
// fast-divisor instances for burst, overflow, reset and STOP_BITS=1 cases.
module tb_uart_tx_fifo;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo_if if_a ();
    uart_tx_fifo_if if_b ();
    uart_tx_fifo_if if_c ();

    logic       tx_a, busy_a, ov_a;
    logic [4:0] cnt_a;
    logic       tx_b, busy_b, ov_b;
    logic [4:0] cnt_b;
    logic       tx_c, busy_c, ov_c;
    logic [2:0] cnt_c;

    uart_tx_fifo u_a (
        .clk(clk), .reset(rst), .s_if(if_a.slave),
        .tx(tx_a), .busy(busy_a), .fifo_count(cnt_a), .overflow(ov_a)
    );

    uart_tx_fifo #(.CLK_FREQ(1000), .BAUD_RATE(100), .STOP_BITS(2), .FIFO_DEPTH(16)) u_b (
        .clk(clk), .reset(rst), .s_if(if_b.slave),
        .tx(tx_b), .busy(busy_b), .fifo_count(cnt_b), .overflow(ov_b)
    );

    uart_tx_fifo #(.CLK_FREQ(1000), .BAUD_RATE(100), .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
        .clk(clk), .reset(rst), .s_if(if_c.slave),
        .tx(tx_c), .busy(busy_c), .fifo_count(cnt_c), .overflow(ov_c)
    );

    int ovc_b = 0;
    int ovc_c = 0;
    always @(posedge clk) begin
        if (ov_b === 1'b1) ovc_b <= ovc_b + 1;
        if (ov_c === 1'b1) ovc_c <= ovc_c + 1;
    end

    typedef struct {
        int         w;
        logic [7:0] d;
        int         t;
    } frm_t;

    frm_t fq[$];
    int   last_start [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic tx_of(input int w);
        case (w)
            0:       return tx_a;
            1:       return tx_b;
            default: return tx_c;
        endcase
    endfunction

    function automatic logic busy_of(input int w);
        case (w)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    task automatic drive(input int w, input logic v, input logic [7:0] d);
        case (w)
            0:       begin if_a.tx_valid = v; if_a.tx_data = d; end
            1:       begin if_b.tx_valid = v; if_b.tx_data = d; end
            default: begin if_c.tx_valid = v; if_c.tx_data = d; end
        endcase
    endtask

    function automatic int nfr(input int w);
        int n = 0;
        foreach (fq[i]) if (fq[i].w == w) n++;
        return n;
    endfunction

    function automatic frm_t get_frm(input int w, input int idx);
        frm_t r;
        int   n = 0;
        r.w = -1; r.d = '0; r.t = 0;
        foreach (fq[i]) begin
            if (fq[i].w == w) begin
                if (n == idx) r = fq[i];
                n++;
            end
        end
        return r;
    endfunction

    task automatic wait_frames(input int w, input int n, input int limit);
        int i = 0;
        while (nfr(w) < n && i < limit) begin
            tick();
            i++;
        end
        check("frames_seen", nfr(w), n);
    endtask

    task automatic wait_idle(input int w, input int limit);
        int i = 0;
        while (busy_of(w) !== 1'b0 && i < limit) begin
            tick();
            i++;
        end
    endtask

    // Line decoder: samples each bit in the middle of its DIV-cycle window.
    task automatic monitor(input int w, input int div, input int nstop);
        logic [7:0] d;
        int         t;
        forever begin
            tick();
            if (tx_of(w) === 1'b0) begin
                t = cyc;
                last_start[w] = t;
                repeat (div / 2) tick();
                check("start_bit", tx_of(w), 1'b0);
                for (int k = 0; k < 8; k++) begin
                    repeat (div) tick();
                    d[k] = tx_of(w);
                end
                for (int k = 0; k < nstop; k++) begin
                    repeat (div) tick();
                    check("stop_bit", tx_of(w), 1'b1);
                end
                fq.push_back('{w, d, t});
            end
        end
    endtask

    initial monitor(0, 434, 2);
    initial monitor(1, 10, 2);
    initial monitor(2, 10, 1);

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        frm_t f, g;
        int   n0, s, ov0, ls0, i;

        last_start[0] = -1; last_start[1] = -1; last_start[2] = -1;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        drive(2, 1'b0, 8'h00);
        rst = 1'b1;
        repeat (3) tick();

        check("rst_tx", tx_b, 1'b1);
        check("rst_ready", if_b.tx_ready, 1'b1);
        check("rst_busy", busy_b, 1'b0);
        check("rst_count", cnt_b, 0);
        check("rst_overflow", ov_b, 1'b0);
        check("rst_tx_a", tx_a, 1'b1);
        check("rst_ready_c", if_c.tx_ready, 1'b1);
        rst = 1'b0;
        tick();

        // Default 434-cycle divisor: push-to-start latency and frame length.
        drive(0, 1'b1, 8'hA5);
        tick();
        n0 = cyc;
        drive(0, 1'b0, 8'h00);
        wait_frames(0, 1, 6000);
        f = get_frm(0, 0);
        check("a_data", f.d, 8'hA5);
        check("a_start_latency", f.t - n0, 2);
        wait_idle(0, 1000);
        check("a_frame_len", cyc - f.t, 4774);

        // Back-to-back bytes, DIV=10 STOP_BITS=2 -> period 111.
        drive(1, 1'b1, 8'h01); tick();
        drive(1, 1'b1, 8'h02); tick();
        drive(1, 1'b1, 8'h04); tick();
        drive(1, 1'b1, 8'h07); tick();
        drive(1, 1'b0, 8'h00);
        wait_frames(1, 4, 1000);
        check("b2b_d0", get_frm(1, 0).d, 8'h01);
        check("b2b_d1", get_frm(1, 1).d, 8'h02);
        check("b2b_d2", get_frm(1, 2).d, 8'h04);
        check("b2b_d3", get_frm(1, 3).d, 8'h07);
        for (int k = 1; k < 4; k++)
            check("b2b_gap", get_frm(1, k).t - get_frm(1, k - 1).t, 111);
        g = get_frm(1, 3);
        wait_idle(1, 300);
        check("b2b_busy_fall", cyc - g.t, 110);

        // 18 pushes with valid held: one in flight, 16 queued, one dropped.
        ov0 = ovc_b;
        for (int k = 0; k < 18; k++) begin
            drive(1, 1'b1, 8'h30 + 8'(k));
            tick();
        end
        drive(1, 1'b0, 8'h00);
        check("full_count", cnt_b, 16);
        check("full_ready", if_b.tx_ready, 1'b0);
        tick();
        check("overflow_pulses", ovc_b - ov0, 1);
        wait_frames(1, 21, 17 * 111 + 300);
        for (int k = 0; k < 17; k++)
            check("full_data", get_frm(1, 4 + k).d, 8'h30 + 8'(k));
        repeat (300) tick();
        check("full_no_extra", nfr(1), 21);
        check("full_drained", cnt_b, 0);

        // Reset during data bit 3 with five bytes still queued.
        ls0 = last_start[1];
        for (int k = 0; k < 6; k++) begin
            drive(1, 1'b1, 8'h40 + 8'(k));
            tick();
        end
        drive(1, 1'b0, 8'h00);
        i = 0;
        while (last_start[1] == ls0 && i < 50) begin
            tick();
            i++;
        end
        s = last_start[1];
        check("rst_mid_started", (s != ls0), 1'b1);
        i = 0;
        while (cyc < s + 43 && i < 100) begin
            tick();
            i++;
        end
        check("rst_mid_queued", cnt_b, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_tx", tx_b, 1'b1);
        check("rst_mid_count", cnt_b, 0);
        check("rst_mid_busy", busy_b, 1'b0);
        check("rst_mid_ready", if_b.tx_ready, 1'b1);
        repeat (300) tick();
        check("rst_mid_no_restart", last_start[1], s);

        // STOP_BITS=1, FIFO_DEPTH=4 -> period 101, ready drops at count 4.
        ov0 = ovc_c;
        for (int k = 0; k < 6; k++) begin
            drive(2, 1'b1, 8'h50 + 8'(k));
            tick();
        end
        drive(2, 1'b0, 8'h00);
        check("c_full_count", cnt_c, 4);
        check("c_full_ready", if_c.tx_ready, 1'b0);
        tick();
        check("c_overflow_pulses", ovc_c - ov0, 1);
        wait_frames(2, 5, 5 * 101 + 300);
        for (int k = 0; k < 5; k++)
            check("c_data", get_frm(2, k).d, 8'h50 + 8'(k));
        check("c_gap", get_frm(2, 1).t - get_frm(2, 0).t, 101);
        repeat (200) tick();
        check("c_no_extra", nfr(2), 5);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter, the send-side counterpart of the existing UART receiver in `fpga_top`. It accepts bytes through a valid/ready handshake into an internal FIFO and serialises them on `UART_TXD`. Frames are 8N2, LSB first, at 115200 baud from the 50 MHz system clock. It carries echo/status traffic (cursor position, write address, error reports) back to the host.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate. The bit divisor is `CLK_FREQ/BAUD_RATE`, truncated, which gives 434.
- `STOP_BITS`, 2: number of stop bits. Legal values are 1 and 2.
- `FIFO_DEPTH`, 16: FIFO entries. Must be a power of two, 2 to 256.

Ports:
- `clk`, in, 1: system clock (`CLOCK_50`). Single clock domain.
- `reset`, in, 1: synchronous, active-high reset.
- `tx_data`, in, 8: byte to send.
- `tx_valid`, in, 1: `tx_data` is valid this cycle.
- `tx_ready`, out, 1: FIFO not full. A push happens on a cycle with `tx_valid && tx_ready`.
- `tx`, out, 1: serial line. Idles high. Drives `UART_TXD`.
- `busy`, out, 1: high while a frame is on the line or the FIFO is non-empty.
- `fifo_count`, out, log2(FIFO_DEPTH)+1: number of occupied entries.
- `overflow`, out, 1: one-cycle pulse when `tx_valid` is asserted while `tx_ready` is low. The byte is dropped.

## Operation
- Reset values: `tx`=1, `tx_ready`=1, `busy`=0, `fifo_count`=0, `overflow`=0. FSM in IDLE, FIFO pointers 0, baud and bit counters 0.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, clear the baud counter and go to START. Otherwise stay; `tx`=1.
  - START: `tx`=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shreg[0] for DIV cycles, then shift right and increment the bit index. After bit 7 completes, go to STOP.
  - STOP: `tx`=1 for STOP_BITS×DIV cycles, then go to IDLE.
- `tx` is a registered output; it never glitches.
- The baud counter runs 0..DIV-1 and is width-sized to hold DIV-1. There is no fractional accumulation.
- FIFO behaviour:
  - Circular buffer; pointers wrap modulo FIFO_DEPTH. `fifo_count` is registered.
  - `tx_ready` is registered as `count != FIFO_DEPTH`.
  - Push while full is rejected, even if a pop occurs the same cycle. `overflow` pulses and the count is unchanged.
  - Simultaneous push and pop leaves the count unchanged.
  - A push into an empty FIFO cannot be popped until the following cycle (no bypass).
- `busy` = (state != IDLE) || (count != 0).
- Reset mid-frame: on the next edge `tx`=1, the FIFO is flushed and in-flight or queued bytes are discarded. No partial frame resumes.

## Timing
- Push to line: a byte pushed into an empty idle block at edge N is popped at N+1. `tx` falls at N+2.
- One frame occupies (1+8+STOP_BITS)×DIV cycles of START/DATA/STOP. With defaults that is 11×434 = 4774 cycles.
- Back-to-back frames have one IDLE cycle between the last stop cycle and the next start bit. Period is 4775 cycles, about 95.5 µs. The receiver tolerates this (+0.02% per frame).
- Bit k (0..7) of a frame starting at cycle S occupies cycles S+(k+1)×DIV to S+(k+2)×DIV−1.
- Throughput: sustained at most one byte per 4775 cycles. The FIFO absorbs bursts of up to FIFO_DEPTH bytes, plus one byte in the shift register.

## Structure
- Shared include `uart_defs.vh`:
  - `CLK_FREQ`, `BAUD_RATE` and the `BAUD_DIV` macro, shared with the existing receiver so both ends agree.
  - FSM state encodings for IDLE/START/DATA/STOP (2 bits).
- Sub-module `sync_fifo`: parameterised width and depth; push/pop/full/empty/count; reusable for a future RX-side buffer.
- `uart_tx_fifo` contains the FSM, baud counter, bit counter, shift register and handshake glue.

## Test plan
- Single byte: push 0xA5 after reset. Sample `tx` mid-bit: 0, then 1,0,1,0,0,1,0,1, then 1,1. Start edge exactly 2 cycles after the push; frame length 4774 cycles.
- Back-to-back: push 0x01, 0x02, 0x04, 0x07 in consecutive cycles. The decoded sequence matches, with start bits exactly 4775 cycles apart. `busy` falls one cycle after the last stop bit ends.
- Full and overflow: push 18 bytes with `tx_valid` held high. The first pops, 16 fill the FIFO, and `tx_ready` drops with `fifo_count`=16. The 18th push gives one `overflow` pulse; exactly 17 bytes appear on the line.
- Reset mid-frame: assert `reset` during DATA bit 3 with 5 bytes queued. Next cycle `tx`=1, `fifo_count`=0, `busy`=0, and no further start bit appears.
- Loopback: wire `tx` to the existing UART receiver in `fpga_top` and send 0x00, 0xFF, 0x55, 0x07. The receiver reports identical bytes via `uart_valid` with `frame_error`=0.
- Parameter sweep: STOP_BITS=1 and FIFO_DEPTH=4. Frame is 10×434 cycles; `tx_ready` deasserts at count 4.
